// File: rtl/ddr_maint_cmd_pkg.sv
// Shared DDR maintenance types: command encoding, FSM states, bus and timer widths.
package ddr_maint_cmd_pkg;

  localparam int unsigned MRS_WIDTH = 16;
  localparam int unsigned TIMER_W   = 16;
  localparam int unsigned A10_BIT   = 10;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_PREA = 3'd1,
    CMD_REF  = 3'd2,
    CMD_MRS  = 3'd3,
    CMD_ZQCS = 3'd4
  } maint_cmd_type;

  typedef enum logic [3:0] {
    M_IDLE     = 4'd0,
    M_PRE      = 4'd1,
    M_PRE_WAIT = 4'd2,
    M_REF      = 4'd3,
    M_REF_WAIT = 4'd4,
    M_MRS      = 4'd5,
    M_MRS_WAIT = 4'd6,
    M_ZQ       = 4'd7,
    M_ZQ_WAIT  = 4'd8
  } maint_fsm_type;

  // Address word for precharge-all: only A10 set.
  function automatic logic [MRS_WIDTH-1:0] prea_addr();
    logic [MRS_WIDTH-1:0] a;
    a          = '0;
    a[A10_BIT] = 1'b1;
    return a;
  endfunction

endpackage

// File: rtl/ddr_maint_cmd_if.sv
// Request/command bus between the DDR controller and the maintenance sequencer.
interface ddr_maint_cmd_if;
  import ddr_maint_cmd_pkg::*;

  logic                 refresh_rdy;
  logic                 mrs_update_rdy;
  logic [MRS_WIDTH-1:0] mrs_update_cmd;
  logic                 bank_open;
  logic                 cmd_valid;
  maint_cmd_type        cmd_type;
  logic [MRS_WIDTH-1:0] cmd_addr;
  logic                 maint_busy;
  logic                 maint_done;

  modport master (
    output refresh_rdy, mrs_update_rdy, mrs_update_cmd, bank_open,
    input  cmd_valid, cmd_type, cmd_addr, maint_busy, maint_done
  );

  modport slave (
    input  refresh_rdy, mrs_update_rdy, mrs_update_cmd, bank_open,
    output cmd_valid, cmd_type, cmd_addr, maint_busy, maint_done
  );

endinterface

// File: rtl/ddr_maint_timer.sv
// Wait down-counter: loaded on entry to a wait state, expire_o marks the last wait cycle.
module ddr_maint_timer
  import ddr_maint_cmd_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] value_i,
  output logic               expire_o,
  output logic               expire_nxt_c
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic               expire_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                   cnt_d = value_i;
    else if (cnt_q != TIMER_W'(0)) cnt_d = cnt_q - TIMER_W'(1);
    expire_nxt_c = (cnt_d == TIMER_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_nxt_c;
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/ddr_maint_cmd.sv
// DDR maintenance sequencer: PREA/REF/MRS issue with tRP/tRFC/tMOD waits.
// Define DDR_MAINT_ZQ_EN to follow every refresh wait with ZQCS and a tZQCS wait.
module ddr_maint_cmd
  import ddr_maint_cmd_pkg::*;
#(
  parameter int unsigned T_RP   = 11,
  parameter int unsigned T_RFC  = 208,
  parameter int unsigned T_MOD  = 24,
  parameter int unsigned T_ZQCS = 64
) (
  input logic            clock_t,
  input logic            reset,
  ddr_maint_cmd_if.slave bus
);

  maint_fsm_type        state_q, state_d, next_cmd;
  logic                 ref_pend_q, ref_pend_d, mrs_pend_q, mrs_pend_d;
  logic [MRS_WIDTH-1:0] mr_q, mr_d;
  logic                 cmd_valid_q, cmd_valid_d;
  maint_cmd_type        cmd_type_q, cmd_type_d;
  logic [MRS_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 tmr_load, tmr_expire, tmr_expire_nxt, final_wait;
  logic [TIMER_W-1:0]   tmr_value;

  ddr_maint_timer u_timer (
    .clk          (clock_t),
    .rst          (reset),
    .load_i       (tmr_load),
    .value_i      (tmr_value),
    .expire_o     (tmr_expire),
    .expire_nxt_c (tmr_expire_nxt)
  );

  always_comb begin
    state_d    = state_q;
    // A pulse coinciding with the issue cycle re-arms the flag.
    ref_pend_d = bus.refresh_rdy    | (ref_pend_q & (state_q != M_REF));
    mrs_pend_d = bus.mrs_update_rdy | (mrs_pend_q & (state_q != M_MRS));
    mr_d       = bus.mrs_update_rdy ? bus.mrs_update_cmd : mr_q;
    next_cmd   = ref_pend_q ? M_REF : (mrs_pend_q ? M_MRS : M_IDLE);

    case (state_q)
      M_IDLE:     if (ref_pend_q || mrs_pend_q) state_d = bus.bank_open ? M_PRE : next_cmd;
      M_PRE:      state_d = M_PRE_WAIT;
      M_REF:      state_d = M_REF_WAIT;
      M_MRS:      state_d = M_MRS_WAIT;
      M_ZQ:       state_d = M_ZQ_WAIT;
      M_PRE_WAIT: if (tmr_expire) state_d = ref_pend_q ? M_REF : M_MRS;
`ifdef DDR_MAINT_ZQ_EN
      M_REF_WAIT: if (tmr_expire) state_d = M_ZQ;
`else
      M_REF_WAIT: if (tmr_expire) state_d = next_cmd;
`endif
      M_MRS_WAIT: if (tmr_expire) state_d = next_cmd;
      M_ZQ_WAIT:  if (tmr_expire) state_d = next_cmd;
      default:    state_d = M_IDLE;
    endcase

    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state_q)
      M_PRE:   begin tmr_load = 1'b1; tmr_value = TIMER_W'(T_RP);   end
      M_REF:   begin tmr_load = 1'b1; tmr_value = TIMER_W'(T_RFC);  end
      M_MRS:   begin tmr_load = 1'b1; tmr_value = TIMER_W'(T_MOD);  end
      M_ZQ:    begin tmr_load = 1'b1; tmr_value = TIMER_W'(T_ZQCS); end
      default: ;
    endcase

    cmd_valid_d = 1'b0;
    cmd_type_d  = CMD_NOP;
    cmd_addr_d  = '0;
    final_wait  = 1'b0;
    // Outputs are registered from the next state so they line up with it.
    case (state_d)
      M_PRE: begin cmd_valid_d = 1'b1; cmd_type_d = CMD_PREA; cmd_addr_d = prea_addr(); end
      M_REF: begin cmd_valid_d = 1'b1; cmd_type_d = CMD_REF;  end
      M_MRS: begin cmd_valid_d = 1'b1; cmd_type_d = CMD_MRS;  cmd_addr_d = mr_d; end
      M_ZQ:  begin cmd_valid_d = 1'b1; cmd_type_d = CMD_ZQCS; end
`ifndef DDR_MAINT_ZQ_EN
      M_REF_WAIT: final_wait = 1'b1;
`endif
      M_MRS_WAIT, M_ZQ_WAIT: final_wait = 1'b1;
      default: ;
    endcase

    busy_d = (state_d != M_IDLE);
    done_d = final_wait & tmr_expire_nxt & ~ref_pend_d & ~mrs_pend_d;
  end

  always_ff @(posedge clock_t or posedge reset) begin
    if (reset) begin
      state_q     <= M_IDLE;
      ref_pend_q  <= 1'b0;
      mrs_pend_q  <= 1'b0;
      mr_q        <= '0;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= CMD_NOP;
      cmd_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ref_pend_q  <= ref_pend_d;
      mrs_pend_q  <= mrs_pend_d;
      mr_q        <= mr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      cmd_addr_q  <= cmd_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.cmd_type   = cmd_type_q;
  assign bus.cmd_addr   = cmd_addr_q;
  assign bus.maint_busy = busy_q;
  assign bus.maint_done = done_q;

endmodule

// File: tb/tb_ddr_maint_cmd.sv
// Scoreboard bench for ddr_maint_cmd; expectations follow DDR_MAINT_ZQ_EN when defined.
module tb_ddr_maint_cmd;
  import ddr_maint_cmd_pkg::*;

  typedef struct {
    int unsigned          cyc;
    maint_cmd_type        typ;
    logic [MRS_WIDTH-1:0] addr;
  } exp_cmd_t;

  logic        clock_t = 1'b0;
  logic        reset   = 1'b1;
  int unsigned cyc     = 0;
  int          n_checks = 0;
  int          n_fail   = 0;
  exp_cmd_t    cq[$];
  int unsigned dq[$];

  ddr_maint_cmd_if bus();

  ddr_maint_cmd #(.T_RP(11), .T_RFC(208), .T_MOD(24), .T_ZQCS(64)) dut (
    .clock_t (clock_t),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clock_t = ~clock_t;
  always @(posedge clock_t) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_cmd(input int unsigned c, input maint_cmd_type t, input logic [MRS_WIDTH-1:0] a);
    exp_cmd_t e;
    e.cyc = c; e.typ = t; e.addr = a;
    cq.push_back(e);
  endtask

  task automatic wait_to(input int unsigned t);
    while (cyc < t) begin @(posedge clock_t); #1; end
  endtask

  task automatic pulse(input bit r, input bit m, input logic [MRS_WIDTH-1:0] v);
    bus.refresh_rdy    = r;
    bus.mrs_update_rdy = m;
    bus.mrs_update_cmd = v;
    @(posedge clock_t); #1;
    bus.refresh_rdy    = 1'b0;
    bus.mrs_update_rdy = 1'b0;
    bus.mrs_update_cmd = 16'hDEAD;
  endtask

  task automatic drain(input string name);
    int i;
    for (i = 0; i < 1000; i++) begin
      if (cq.size() == 0 && dq.size() == 0 && !bus.maint_busy) break;
      @(posedge clock_t); #1;
    end
    check({name, "_drain"}, (i < 1000), longint'(cq.size() + dq.size()), 0);
    bus.bank_open = 1'b0;
    repeat (5) @(posedge clock_t);
    #1;
  endtask

  // Monitor: pops expected commands/done pulses whenever the DUT presents them.
  always @(negedge clock_t) begin
    if (!reset) begin
      if (bus.cmd_valid) begin
        if (cq.size() == 0) begin
          check("unexpected_cmd", 1'b0, longint'(bus.cmd_type), longint'(CMD_NOP));
        end else begin
          exp_cmd_t e;
          e = cq.pop_front();
          n_checks++;
          if (e.cyc != cyc || e.typ != bus.cmd_type || e.addr != bus.cmd_addr) begin
            n_fail++;
            $display("FAIL cmd: actual cyc=%0d type=%s addr=0x%04h expected cyc=%0d type=%s addr=0x%04h",
                     cyc, bus.cmd_type.name(), bus.cmd_addr, e.cyc, e.typ.name(), e.addr);
          end
        end
      end else begin
        check("nop_when_idle", bus.cmd_type == CMD_NOP, longint'(bus.cmd_type), longint'(CMD_NOP));
      end
      if (bus.maint_done) begin
        if (dq.size() == 0) check("unexpected_done", 1'b0, longint'(cyc), 0);
        else begin
          int unsigned d;
          d = dq.pop_front();
          check("done_cycle", d == cyc, longint'(cyc), longint'(d));
        end
      end
    end
  end

  initial begin
    int unsigned n;
    bus.refresh_rdy    = 1'b0;
    bus.mrs_update_rdy = 1'b0;
    bus.mrs_update_cmd = '0;
    bus.bank_open      = 1'b0;

    // Reset values
    repeat (3) @(negedge clock_t);
    check("rst_valid", bus.cmd_valid == 1'b0, longint'(bus.cmd_valid), 0);
    check("rst_type",  bus.cmd_type == CMD_NOP, longint'(bus.cmd_type), longint'(CMD_NOP));
    check("rst_addr",  bus.cmd_addr == '0, longint'(bus.cmd_addr), 0);
    check("rst_busy",  bus.maint_busy == 1'b0, longint'(bus.maint_busy), 0);
    check("rst_done",  bus.maint_done == 1'b0, longint'(bus.maint_done), 0);
    @(posedge clock_t); #1;
    reset = 1'b0;

    // Refresh with banks closed
    wait_to(10);
    n = cyc;
    push_cmd(n + 2, CMD_REF, '0);
`ifdef DDR_MAINT_ZQ_EN
    push_cmd(n + 211, CMD_ZQCS, '0);
    dq.push_back(n + 275);
`else
    dq.push_back(n + 210);
`endif
    pulse(1'b1, 1'b0, '0);
    drain("t_ref");

    // MRS with a bank open
    n = cyc;
    bus.bank_open = 1'b1;
    push_cmd(n + 2, CMD_PREA, 16'h0400);
    push_cmd(n + 14, CMD_MRS, 16'h0005);
    dq.push_back(n + 38);
    pulse(1'b0, 1'b1, 16'h0005);
    drain("t_mrs");

    // Simultaneous refresh and MRS: PREA, REF, MRS, single done
    n = cyc;
    bus.bank_open = 1'b1;
    push_cmd(n + 2, CMD_PREA, 16'h0400);
    push_cmd(n + 14, CMD_REF, '0);
`ifdef DDR_MAINT_ZQ_EN
    push_cmd(n + 223, CMD_ZQCS, '0);
    push_cmd(n + 288, CMD_MRS, 16'h00A3);
    dq.push_back(n + 312);
`else
    push_cmd(n + 223, CMD_MRS, 16'h00A3);
    dq.push_back(n + 247);
`endif
    pulse(1'b1, 1'b1, 16'h00A3);
    drain("t_both");

    // Two MRS updates during refresh wait merge into one MRS with the last value
    n = cyc;
    push_cmd(n + 2, CMD_REF, '0);
`ifdef DDR_MAINT_ZQ_EN
    push_cmd(n + 211, CMD_ZQCS, '0);
    push_cmd(n + 276, CMD_MRS, 16'h0002);
    dq.push_back(n + 300);
`else
    push_cmd(n + 211, CMD_MRS, 16'h0002);
    dq.push_back(n + 235);
`endif
    pulse(1'b1, 1'b0, '0);
    wait_to(n + 20);
    pulse(1'b0, 1'b1, 16'h0001);
    wait_to(n + 40);
    pulse(1'b0, 1'b1, 16'h0002);
    drain("t_merge_mrs");

    // Repeat refresh while pending is merged
    n = cyc;
    bus.bank_open = 1'b1;
    push_cmd(n + 2, CMD_PREA, 16'h0400);
    push_cmd(n + 14, CMD_REF, '0);
`ifdef DDR_MAINT_ZQ_EN
    push_cmd(n + 223, CMD_ZQCS, '0);
    dq.push_back(n + 287);
`else
    dq.push_back(n + 222);
`endif
    pulse(1'b1, 1'b0, '0);
    wait_to(n + 5);
    pulse(1'b1, 1'b0, '0);
    drain("t_merge_ref");

    // Refresh arriving in the REF issue cycle re-arms and issues a second REF
    n = cyc;
    push_cmd(n + 2, CMD_REF, '0);
`ifdef DDR_MAINT_ZQ_EN
    push_cmd(n + 211, CMD_ZQCS, '0);
    push_cmd(n + 276, CMD_REF, '0);
    push_cmd(n + 485, CMD_ZQCS, '0);
    dq.push_back(n + 549);
`else
    push_cmd(n + 211, CMD_REF, '0);
    dq.push_back(n + 419);
`endif
    pulse(1'b1, 1'b0, '0);
    wait_to(n + 2);
    pulse(1'b1, 1'b0, '0);
    drain("t_rearm");

    // Reset during refresh wait aborts the sequence
    n = cyc;
    push_cmd(n + 2, CMD_REF, '0);
    pulse(1'b1, 1'b0, '0);
    wait_to(n + 50);
    check("busy_in_wait", bus.maint_busy == 1'b1, longint'(bus.maint_busy), 1);
    reset = 1'b1;
    #1;
    check("abort_valid", bus.cmd_valid == 1'b0, longint'(bus.cmd_valid), 0);
    check("abort_type",  bus.cmd_type == CMD_NOP, longint'(bus.cmd_type), longint'(CMD_NOP));
    check("abort_addr",  bus.cmd_addr == '0, longint'(bus.cmd_addr), 0);
    check("abort_busy",  bus.maint_busy == 1'b0, longint'(bus.maint_busy), 0);
    check("abort_done",  bus.maint_done == 1'b0, longint'(bus.maint_done), 0);
    @(posedge clock_t); #1;
    reset = 1'b0;
    repeat (300) @(posedge clock_t);
    #1;
    check("abort_quiet", bus.maint_busy == 1'b0, longint'(bus.maint_busy), 0);

    // New request after the abort is served normally
    n = cyc;
    push_cmd(n + 2, CMD_REF, '0);
`ifdef DDR_MAINT_ZQ_EN
    push_cmd(n + 211, CMD_ZQCS, '0);
    dq.push_back(n + 275);
`else
    dq.push_back(n + 210);
`endif
    pulse(1'b1, 1'b0, '0);
    drain("t_after_abort");

    check("cmd_queue_empty",  cq.size() == 0, longint'(cq.size()), 0);
    check("done_queue_empty", dq.size() == 0, longint'(dq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
